evu_counter_bank: RTL
=====================

// Module: evu_counter_bank
// PURPOSE
//  Consumer end of the event-unit path: takes the 1-bit event lines produced by per-counter
//  event muxes and accumulates them in a bank of 64-bit event counters.
//  Owns each counter's 4-bit event-select register (fed back to the muxes).
//  Exposes counters, selects, inhibit and overflow state over a simple CSR req/gnt/rvalid port.
//  Raises an interrupt on counter wrap.
// PARAMETERS
//  NR_COUNTERS  4   number of counters / event lines (1..8)
//  CNT_W        64  counter width in bits
//  SEL_W        4   event-select width (matches mux select encoding)
// PORTS
//  clk_i         in   1               core clock
//  rst_i         in   1               asynchronous reset, active-high
//  evt_i         in   NR_COUNTERS     registered event pulse per counter (1 = one event this cycle)
//  debug_mode_i  in   1               core in debug mode: all counting frozen
//  sel_o         out  NR_COUNTERS*SEL_W  event-select per counter, to the muxes
//  csr_req_i     in   1               CSR access request
//  csr_we_i      in   1               1 = write, 0 = read
//  csr_addr_i    in   5               {kind[1:0], idx[2:0]}
//  csr_wdata_i   in   CNT_W           write data
//  csr_gnt_o     out  1               request accepted this cycle
//  csr_rvalid_o  out  1               response valid (reads and writes)
//  csr_rdata_o   out  CNT_W           read data, valid with rvalid
//  csr_err_o     out  1               bad address, valid with rvalid
//  irq_o         out  1               overflow interrupt (level)
// BEHAVIOUR
//  Reset (async, rst_i=1): all counters 0, all sel 0, inhibit all-ones, ovf 0,
//   rvalid/err/irq 0, rdata 0. Reset mid-access drops the pending response.
//  Address map, kind:
//   0 = COUNT[idx] (CNT_W bits)
//   1 = SEL[idx] (SEL_W bits, upper bits read 0, ignored on write)
//   2 = INHIBIT (NR_COUNTERS bits, idx must be 0)
//   3 = OVF (idx must be 0; write-1-to-clear).
//   idx >= NR_COUNTERS, or idx != 0 for kind 2/3: access is accepted and has no effect;
//   the response returns rdata 0 with err 1.
//  Handshake: csr_gnt_o = csr_req_i (always ready, one access per cycle).
//   The response is registered: rvalid is high exactly one cycle after each granted cycle.
//   Reads return the value present in the grant cycle, before that cycle's increment or write.
//  Count rule, per counter k, each cycle:
//   inc_k = evt_i[k] & ~inhibit[k] & ~debug_mode_i & (sel[k] != 0).
//   cnt_k <= cnt_k + inc_k, modulo 2^CNT_W.
//  Wrap: if inc_k and cnt_k is all-ones, cnt_k becomes 0 and ovf[k] sets (sticky).
//  Simultaneous events:
//   - CSR write to COUNT[k] in the same cycle as inc_k: the written value wins, the increment
//     is dropped, and no ovf is set.
//   - W1C of ovf[k] in the same cycle as a new wrap of k: the set wins (ovf[k] stays 1).
//   - A write to SEL[k] takes effect from the next cycle; an evt_i[k] in the write cycle is
//     still counted under the old sel.
//  irq_o is registered: irq_o <= |ovf_next. It stays high until every ovf bit is cleared.
//  sel_o is driven directly from the SEL registers (no added latency).
// STRUCTURE
//  evu_pkg (shared):
//   - evu_csr_kind_e {EVU_COUNT, EVU_SEL, EVU_INHIBIT, EVU_OVF}
//   - select encodings EVU_SEL_ICMISS=4'h2 .. EVU_SEL_IFEMPTY=4'hF, with 0 meaning "off"
//   - EVU_ADDR_W=5
//  Sub-module evu_counter (one instance per counter): inputs inc, we, wdata; outputs count and
//  a wrap pulse. The top level holds the CSR decode, the inhibit/ovf/sel registers and the
//  response pipeline.
// TESTING
//  1 Reset state: read all kinds -> COUNT=0, SEL=0, INHIBIT=4'hF, OVF=0, irq_o=0; rvalid 1 cycle after gnt.
//  2 Basic count: SEL[1]=2, INHIBIT=0, 5 pulses on evt_i[1] -> COUNT[1]=5, others 0.
//    Repeat with debug_mode_i=1 -> no change.
//  3 Wrap: write COUNT[0]=64'hFFFF_FFFF_FFFF_FFFE, 2 events -> COUNT[0]=0, OVF=4'b0001, irq_o=1
//    the next cycle; W1C OVF=1 -> irq_o=0.
//  4 Collisions:
//    - write COUNT[2]=100 in the same cycle as evt_i[2] -> reads 100.
//    - W1C ovf[0] in the same cycle as a wrap -> ovf[0] stays 1.
//  5 Bad address: read kind 0 idx 6 (NR_COUNTERS=4) -> rdata 0, err 1, no state change.
//    Read-before-increment: read COUNT[1] in the same cycle as an event returns the pre-increment value.
//  6 Reset mid-operation: rst_i pulsed during an outstanding read with events active -> no rvalid,
//    all state back to reset values.

Source files
------------

// File: rtl/evu_pkg.sv
// Shared types and constants for the event unit: CSR address layout and event-select encodings.
package evu_pkg;

  localparam int unsigned EVU_ADDR_W = 5;
  localparam int unsigned EVU_KIND_W = 2;
  localparam int unsigned EVU_IDX_W  = 3;
  localparam int unsigned EVU_SEL_W  = 4;

  typedef enum logic [EVU_KIND_W-1:0] {
    EVU_COUNT   = 2'd0,
    EVU_SEL     = 2'd1,
    EVU_INHIBIT = 2'd2,
    EVU_OVF     = 2'd3
  } evu_csr_kind_e;

  typedef struct packed {
    evu_csr_kind_e          kind;
    logic [EVU_IDX_W-1:0]   idx;
  } evu_csr_addr_t;

  // Select value 0 switches a counter off; the muxes own the meaning of the rest.
  localparam logic [EVU_SEL_W-1:0] EVU_SEL_OFF     = 4'h0;
  localparam logic [EVU_SEL_W-1:0] EVU_SEL_ICMISS  = 4'h2;
  localparam logic [EVU_SEL_W-1:0] EVU_SEL_IFEMPTY = 4'hF;

endpackage

// File: rtl/evu_counter.sv
// Single event counter: CSR write beats increment; wrap_c flags an increment out of all-ones.
module evu_counter #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  input  logic             we,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] count,
  output logic             wrap_c
);

  assign wrap_c = inc & ~we & (&count);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (we) begin
      count <= wdata;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/evu_counter_bank.sv
// Bank of event counters with per-counter select, inhibit and sticky overflow, behind a
// single-cycle CSR port with a registered response.
module evu_counter_bank
  import evu_pkg::*;
#(
  parameter int unsigned NR_COUNTERS = 4,
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned SEL_W       = EVU_SEL_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NR_COUNTERS-1:0]       evt_i,
  input  logic                         debug_mode_i,
  output logic [NR_COUNTERS*SEL_W-1:0] sel_o,
  input  logic                         csr_req_i,
  input  logic                         csr_we_i,
  input  logic [EVU_ADDR_W-1:0]        csr_addr_i,
  input  logic [CNT_W-1:0]             csr_wdata_i,
  output logic                         csr_gnt_o,
  output logic                         csr_rvalid_o,
  output logic [CNT_W-1:0]             csr_rdata_o,
  output logic                         csr_err_o,
  output logic                         irq_o
);

  logic [SEL_W-1:0]       sel_q [NR_COUNTERS];
  logic [CNT_W-1:0]       cnt_q [NR_COUNTERS];
  logic [NR_COUNTERS-1:0] inhibit_q;
  logic [NR_COUNTERS-1:0] ovf_q;
  logic [NR_COUNTERS-1:0] ovf_next_c;
  logic [NR_COUNTERS-1:0] inc_c;
  logic [NR_COUNTERS-1:0] cnt_we_c;
  logic [NR_COUNTERS-1:0] sel_we_c;
  logic [NR_COUNTERS-1:0] wrap_c;
  logic [NR_COUNTERS-1:0] idx_hit_c;
  logic [NR_COUNTERS-1:0] w1c_c;
  evu_csr_addr_t          addr_c;
  logic                   addr_ok_c;
  logic                   wr_c;
  logic [CNT_W-1:0]       rdata_c;

  assign addr_c    = evu_csr_addr_t'(csr_addr_i);
  assign csr_gnt_o = csr_req_i;
  assign wr_c      = csr_req_i & csr_we_i & addr_ok_c;

  // Per-counter address match, count/select enables and counter instances.
  for (genvar k = 0; k < NR_COUNTERS; k++) begin : g_cnt
    assign idx_hit_c[k] = (addr_c.idx == EVU_IDX_W'(k));
    assign cnt_we_c[k]  = wr_c & (addr_c.kind == EVU_COUNT) & idx_hit_c[k];
    assign sel_we_c[k]  = wr_c & (addr_c.kind == EVU_SEL) & idx_hit_c[k];
    assign inc_c[k]     = evt_i[k] & ~inhibit_q[k] & ~debug_mode_i & (sel_q[k] != '0);
    assign sel_o[k*SEL_W +: SEL_W] = sel_q[k];

    evu_counter #(.CNT_W(CNT_W)) u_counter (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc    (inc_c[k]),
      .we     (cnt_we_c[k]),
      .wdata  (csr_wdata_i),
      .count  (cnt_q[k]),
      .wrap_c (wrap_c[k])
    );
  end

  // A fresh wrap outranks a same-cycle clear.
  assign w1c_c      = (wr_c && addr_c.kind == EVU_OVF) ? csr_wdata_i[NR_COUNTERS-1:0] : '0;
  assign ovf_next_c = (ovf_q & ~w1c_c) | wrap_c;

  always_comb begin
    addr_ok_c = 1'b0;
    case (addr_c.kind)
      EVU_COUNT, EVU_SEL: addr_ok_c = (32'(addr_c.idx) < NR_COUNTERS);
      default:            addr_ok_c = (addr_c.idx == '0);
    endcase
  end

  // Read mux sees pre-update state, so reads return the grant-cycle value.
  always_comb begin
    rdata_c = '0;
    if (addr_ok_c) begin
      case (addr_c.kind)
        EVU_COUNT: begin
          for (int unsigned k = 0; k < NR_COUNTERS; k++) begin
            if (idx_hit_c[k]) rdata_c = cnt_q[k];
          end
        end
        EVU_SEL: begin
          for (int unsigned k = 0; k < NR_COUNTERS; k++) begin
            if (idx_hit_c[k]) rdata_c = CNT_W'(sel_q[k]);
          end
        end
        EVU_INHIBIT: rdata_c = CNT_W'(inhibit_q);
        default:     rdata_c = CNT_W'(ovf_q);
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NR_COUNTERS; k++) sel_q[k] <= '0;
      inhibit_q    <= '1;
      ovf_q        <= '0;
      irq_o        <= 1'b0;
      csr_rvalid_o <= 1'b0;
      csr_err_o    <= 1'b0;
      csr_rdata_o  <= '0;
    end else begin
      for (int unsigned k = 0; k < NR_COUNTERS; k++) begin
        if (sel_we_c[k]) sel_q[k] <= csr_wdata_i[SEL_W-1:0];
      end
      if (wr_c && addr_c.kind == EVU_INHIBIT) inhibit_q <= csr_wdata_i[NR_COUNTERS-1:0];
      ovf_q        <= ovf_next_c;
      irq_o        <= |ovf_next_c;
      csr_rvalid_o <= csr_req_i;
      csr_err_o    <= csr_req_i & ~addr_ok_c;
      if (csr_req_i) csr_rdata_o <= rdata_c;
    end
  end

endmodule
